// File: rtl/tt_keypad_scan_if.sv
// Keypad pin and key-event bundle between the scanner and its consumers.
// master: the scanner (drives rows and key outputs, reads columns).
// slave: the keypad/consumer side (drives columns, reads everything else).
interface tt_keypad_scan_if;
  logic [3:0] col_in;    // active-low columns, pulled up externally
  logic [3:0] row_out;   // one-hot active-low row drive
  logic [3:0] key_4;     // code of the last accepted key
  logic       pulse;     // one-cycle strobe on a newly accepted key
  logic       key_held;  // high while the accepted key stays pressed

  modport master (
    input  col_in,
    output row_out,
    output key_4,
    output pulse,
    output key_held
  );

  modport slave (
    output col_in,
    input  row_out,
    input  key_4,
    input  pulse,
    input  key_held
  );
endinterface

// File: rtl/tt_keypad_scan.sv
// 4x4 keypad scanner: row scan, 2-flop column sync, frame-level debounce, key encode.
// Latency: key stable from frame N start -> pulse registered at end of frame N+DEBOUNCE_CNT-1.
// No backpressure: pulse is a one-cycle strobe, key_4 holds the code until the next press.
// Optional auto-repeat: define TT_KEYPAD_REPEAT_EN (adds parameter REPEAT_FRAMES).
module tt_keypad_scan #(
  parameter int SCAN_DIV     = 4,
  parameter int DEBOUNCE_CNT = 3
`ifdef TT_KEYPAD_REPEAT_EN
  , parameter int REPEAT_FRAMES = 32
`endif
) (
  input  logic               clk,
  input  logic               rst,
  tt_keypad_scan_if.master   io_kp
);

  localparam int DW = 8;   // dwell counter width, covers SCAN_DIV up to 255
  localparam int CW = 4;   // stable counter width, covers DEBOUNCE_CNT up to 15

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PRESSED = 1'b1
  } state_t;

  // Synchronizer
  logic [3:0]    r_col_s1;
  logic [3:0]    r_col_s2;
  // Row sequencing
  logic [DW-1:0] r_dwell;
  logic [1:0]    r_row;
  logic [3:0]    r_row_out;
  // Per-frame accumulator: first (lowest) key seen so far in this frame
  logic          r_acc_vld;
  logic [3:0]    r_acc_code;
  // Debounce history
  logic          r_prev_none;
  logic [3:0]    r_prev_code;
  logic [CW-1:0] r_stable_cnt;
  // FSM and registered outputs
  state_t        r_state;
  logic [3:0]    r_key;
  logic          r_pulse;
  logic          r_held;

  logic          w_last_dwell;
  logic          w_frame_end;
  logic [1:0]    w_row_nxt;
  logic [3:0]    w_col_hit;
  logic          w_col_any;
  logic [1:0]    w_col_idx;
  logic [3:0]    w_row_code;
  logic          w_res_none;
  logic [3:0]    w_res_code;
  logic          w_same;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_stable;
  state_t        w_state_nxt;
  logic [3:0]    w_key_nxt;
  logic          w_pulse_nxt;
  logic          w_held_nxt;

  assign w_last_dwell = (r_dwell == DW'(SCAN_DIV - 1));
  assign w_frame_end  = w_last_dwell && (r_row == 2'd3);
  assign w_row_nxt    = r_row + 2'd1;
  assign w_col_hit    = ~r_col_s2;
  assign w_col_any    = |w_col_hit;
  assign w_row_code   = {r_row, w_col_idx};

  // Two-flop synchronizer; idle level is all columns released (high)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col_s1 <= 4'b1111;
      r_col_s2 <= 4'b1111;
    end else begin
      r_col_s1 <= io_kp.col_in;
      r_col_s2 <= r_col_s1;
    end
  end

  // Dwell counter and row advance; row_out kept registered alongside the row index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dwell   <= '0;
      r_row     <= 2'd0;
      r_row_out <= 4'b1110;
    end else if (w_last_dwell) begin
      r_dwell   <= '0;
      r_row     <= w_row_nxt;
      r_row_out <= ~(4'b0001 << w_row_nxt);
    end else begin
      r_dwell   <= r_dwell + DW'(1);
    end
  end

  // Lowest low column in the current row (column 0 has priority)
  always_comb begin
    w_col_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (w_col_hit[i]) w_col_idx = 2'(i);
    end
  end

  // Frame result: rows are scanned in ascending order, so the first hit is the lowest code
  always_comb begin
    w_res_none = 1'b1;
    w_res_code = 4'd0;
    if (r_acc_vld) begin
      w_res_none = 1'b0;
      w_res_code = r_acc_code;
    end else if (w_col_any) begin
      w_res_none = 1'b0;
      w_res_code = w_row_code;
    end
  end

  // Accumulate the first key of the frame; restart at every frame end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc_vld  <= 1'b0;
      r_acc_code <= 4'd0;
    end else if (w_frame_end) begin
      r_acc_vld  <= 1'b0;
      r_acc_code <= 4'd0;
    end else if (w_last_dwell && !r_acc_vld && w_col_any) begin
      r_acc_vld  <= 1'b1;
      r_acc_code <= w_row_code;
    end
  end

  // Stability count: saturating run length of identical frame results
  always_comb begin
    w_same    = (w_res_none == r_prev_none) && (w_res_none || (w_res_code == r_prev_code));
    w_cnt_nxt = CW'(1);
    if (w_same) begin
      if (r_stable_cnt >= CW'(DEBOUNCE_CNT)) w_cnt_nxt = CW'(DEBOUNCE_CNT);
      else                                   w_cnt_nxt = r_stable_cnt + CW'(1);
    end
    w_stable = (w_cnt_nxt == CW'(DEBOUNCE_CNT));
  end

  // Debounce history updated once per frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev_none  <= 1'b1;
      r_prev_code  <= 4'd0;
      r_stable_cnt <= '0;
    end else if (w_frame_end) begin
      r_prev_none  <= w_res_none;
      r_prev_code  <= w_res_code;
      r_stable_cnt <= w_cnt_nxt;
    end
  end

`ifdef TT_KEYPAD_REPEAT_EN
  logic [15:0] r_rep_cnt;
  logic [15:0] w_rep_nxt;
  logic [15:0] w_rep_inc;

  assign w_rep_inc = r_rep_cnt + 16'd1;

  // Frames elapsed in PRESSED since the last pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_rep_cnt <= '0;
    else     r_rep_cnt <= w_rep_nxt;
  end
`endif

  // FSM next state and next registered outputs; everything acts at frame end
  always_comb begin
    w_state_nxt = r_state;
    w_key_nxt   = r_key;
    w_pulse_nxt = 1'b0;
    w_held_nxt  = r_held;
`ifdef TT_KEYPAD_REPEAT_EN
    w_rep_nxt   = r_rep_cnt;
`endif
    case (r_state)
      ST_IDLE: begin
`ifdef TT_KEYPAD_REPEAT_EN
        w_rep_nxt = '0;
`endif
        if (w_frame_end && w_stable && !w_res_none) begin
          w_state_nxt = ST_PRESSED;
          w_key_nxt   = w_res_code;
          w_pulse_nxt = 1'b1;
          w_held_nxt  = 1'b1;
        end
      end
      ST_PRESSED: begin
        // A different key while pressed is ignored until a debounced release
        if (w_frame_end && w_stable && w_res_none) begin
          w_state_nxt = ST_IDLE;
          w_held_nxt  = 1'b0;
`ifdef TT_KEYPAD_REPEAT_EN
          w_rep_nxt   = '0;
`endif
        end
`ifdef TT_KEYPAD_REPEAT_EN
        else if (w_frame_end) begin
          if (w_rep_inc == 16'(REPEAT_FRAMES)) begin
            w_pulse_nxt = 1'b1;
            w_rep_nxt   = '0;
          end else begin
            w_rep_nxt   = w_rep_inc;
          end
        end
`endif
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_held_nxt  = 1'b0;
      end
    endcase
  end

  // FSM state and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_key   <= 4'd0;
      r_pulse <= 1'b0;
      r_held  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_key   <= w_key_nxt;
      r_pulse <= w_pulse_nxt;
      r_held  <= w_held_nxt;
    end
  end

  assign io_kp.row_out  = r_row_out;
  assign io_kp.key_4    = r_key;
  assign io_kp.pulse    = r_pulse;
  assign io_kp.key_held = r_held;

endmodule

// File: tb/tb_tt_keypad_scan.sv
// Randomized bench for tt_keypad_scan against a frame-level keypad model.
// Key sets change only on frame boundaries; every cycle is checked.
// Build with TT_KEYPAD_REPEAT_EN to exercise auto-repeat (REPEAT_FRAMES=4).
module tb_tt_keypad_scan;

  localparam int SD  = 4;
  localparam int DEB = 3;
  localparam int RF  = 4;
  localparam int FRAME = 4 * SD;

  logic clk = 1'b0;
  logic rst = 1'b1;

  tt_keypad_scan_if kp ();

`ifdef TT_KEYPAD_REPEAT_EN
  tt_keypad_scan #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DEB), .REPEAT_FRAMES(RF)) dut (
    .clk(clk), .rst(rst), .io_kp(kp));
`else
  tt_keypad_scan #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DEB)) dut (
    .clk(clk), .rst(rst), .io_kp(kp));
`endif

  always #5 clk = ~clk;

  // Physical keypad: bit k of mask = key with code k (row k/4, col k%4) is closed
  logic [15:0] mask = 16'h0;
  always_comb begin
    kp.col_in = 4'b1111;
    for (int r = 0; r < 4; r++)
      if (!kp.row_out[r])
        for (int cc = 0; cc < 4; cc++)
          if (mask[r*4+cc]) kp.col_in[cc] = 1'b0;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  int       cyc;
  int       hist[$];      // one frame result per completed frame, -1 = no key
  bit       pressed;
  int       exp_key;
  bit       exp_held;
  bit       exp_pulse;
  int       rep_frames;

  task automatic model_reset();
    cyc = 0; hist.delete(); pressed = 0; exp_key = 0;
    exp_held = 0; exp_pulse = 0; rep_frames = 0;
  endtask

  function automatic int lowest_key(input logic [15:0] m);
    for (int k = 0; k < 16; k++) if (m[k]) return k;
    return -1;
  endfunction

  task automatic model_frame_end();
    int res, run;
    res = lowest_key(mask);
    hist.push_back(res);
    run = 0;
    for (int i = hist.size() - 1; i >= 0 && hist[i] == res && run < DEB; i--) run++;
    if (!pressed) begin
      if (run == DEB && res >= 0) begin
        pressed = 1; exp_key = res; exp_held = 1; exp_pulse = 1; rep_frames = 0;
      end
    end else if (run == DEB && res < 0) begin
      pressed = 0; exp_held = 0; rep_frames = 0;
    end else begin
`ifdef TT_KEYPAD_REPEAT_EN
      rep_frames++;
      if (rep_frames == RF) begin exp_pulse = 1; rep_frames = 0; end
`endif
    end
  endtask

  // Check the current cycle, then advance one clock
  task automatic run_cycle();
    logic [3:0] exp_row;
    exp_row = ~(4'b0001 << ((cyc / SD) % 4));
    chk("row_out", 32'(kp.row_out), 32'(exp_row));
    chk("pulse", 32'(kp.pulse), 32'(exp_pulse));
    chk("key_4", 32'(kp.key_4), 32'(exp_key));
    chk("key_held", 32'(kp.key_held), 32'(exp_held));
    exp_pulse = 0;
    @(posedge clk); #1;
    if (cyc % FRAME == FRAME - 1) model_frame_end();
    cyc++;
  endtask

  task automatic run_frames(input logic [15:0] m, input int nf);
    mask = m;
    for (int f = 0; f < nf; f++)
      for (int k = 0; k < FRAME; k++) run_cycle();
  endtask

  logic [15:0] seg_mask[$];
  int          seg_len[$];

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_row_out", 32'(kp.row_out), 32'h0000000e);
    chk("rst_pulse", 32'(kp.pulse), 32'h0);
    rst = 1'b0;

    // Hold key 9 long enough to be accepted, then reset in the middle of row 1
    run_frames(16'h0200, 4);
    for (int k = 0; k < 5; k++) run_cycle();
    #2 rst = 1'b1;
    #1;
    chk("midrst_row_out", 32'(kp.row_out), 32'h0000000e);
    chk("midrst_key_4", 32'(kp.key_4), 32'h0);
    chk("midrst_pulse", 32'(kp.pulse), 32'h0);
    chk("midrst_key_held", 32'(kp.key_held), 32'h0);
    mask = 16'h0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Directed sequence from the plan, then random segments
    seg_mask = '{16'h0200, 16'h0000, 16'h1008, 16'h0000, 16'h0020, 16'h0000,
                 16'h0200, 16'h0000, 16'h0200, 16'h0000, 16'h1000, 16'h0000,
                 16'h0100, 16'h0040};
    seg_len  = '{5, 4, 4, 4, 2, 4, 4, 2, 3, 4, 13, 4, 4, 4};
    for (int s = 0; s < 40; s++) begin
      int kind;
      kind = $urandom_range(0, 3);
      case (kind)
        0:       seg_mask.push_back(16'h0);
        1:       seg_mask.push_back(16'h1 << $urandom_range(0, 15));
        2:       seg_mask.push_back(16'(($urandom() & 16'hffff) | 16'h0001 << $urandom_range(0, 15)));
        default: seg_mask.push_back(16'(16'h1 << $urandom_range(0, 15) | 16'h1 << $urandom_range(0, 15)));
      endcase
      seg_len.push_back($urandom_range(1, 6));
    end
    for (int s = 0; s < seg_mask.size(); s++) run_frames(seg_mask[s], seg_len[s]);
    run_frames(16'h0, 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Watchdog: bounded run regardless of stimulus
  initial begin
    #2000000;
    n_tests++;
    n_fail++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
